// File: rtl/v_inst_queue_pkg.sv
// Shared types and constants for the vector instruction queue.
// Holds vector opcodes, default sizes, queue state and legality check.
package v_inst_queue_pkg;

   localparam int VIQ_DEPTH = 4;
   localparam int VIQ_XLEN  = 64;
   localparam int VIQ_IW    = 32;

   localparam logic [6:0] OP_VARITH = 7'b1010111;
   localparam logic [6:0] OP_VLOAD  = 7'b0000111;
   localparam logic [6:0] OP_VSTORE = 7'b0100111;

   typedef enum logic [1:0] {
      IQ_EMPTY,
      IQ_PARTIAL,
      IQ_FULL
   } iq_state_e;

   function automatic logic is_vec_op(
      input logic [6:0] op
   );
      return (op == OP_VARITH) ||
             (op == OP_VLOAD)  ||
             (op == OP_VSTORE);
   endfunction

endpackage

// File: rtl/v_iq_fifo.sv
// Storage array for the vector instruction queue, no reset on contents.
// Ports: clk, wr_en/wr_idx/wr_data write side, rd_idx/rd_data async read.
module v_iq_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 96,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_idx,
   input  logic [W-1:0]  wr_data,
   input  logic [AW-1:0] rd_idx,
   output logic [W-1:0]  rd_data
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/v_inst_queue.sv
// Vector dispatch queue: in-order {inst, rs1} buffer toward vector core.
// Ports: clk, rst (async low), flush_i, in_* push side, out_* pop side,
// count_o, idle_o, err_o. Optional same-cycle bypass: V_IQ_BYPASS_EN.
module v_inst_queue
   import v_inst_queue_pkg::*;
#(
   parameter int DEPTH = VIQ_DEPTH,
   parameter int XLEN  = VIQ_XLEN,
   parameter int IW    = VIQ_IW,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [IW-1:0]   in_inst_i,
   input  logic [XLEN-1:0] in_rs1_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [IW-1:0]   out_inst_o,
   output logic [XLEN-1:0] out_rs1_o,
   output logic [AW:0]     count_o,
   output logic            idle_o,
   output logic            err_o
);

   localparam int W = IW + XLEN;

   logic [AW:0]   rd_q;
   logic [AW:0]   wr_q;
   logic          err_q;
   iq_state_e     state;
   logic          empty;
   logic          full;
   logic          legal;
   logic          hs;
   logic          push;
   logic          pop;
   logic          byp;
   logic          byp_take;
   logic [W-1:0]  rd_data;

   assign empty = (rd_q == wr_q);
   assign full  = (rd_q[AW-1:0] == wr_q[AW-1:0]) &&
                  (rd_q[AW] != wr_q[AW]);

   always_comb begin
      state = IQ_PARTIAL;
      if (empty) begin
         state = IQ_EMPTY;
      end else if (full) begin
         state = IQ_FULL;
      end
   end

   assign legal = is_vec_op(in_inst_i[6:0]);

   // rst gates ready so the source sees 0 for the whole reset window.
   assign in_ready_o = rst && (state != IQ_FULL) && !flush_i;
   assign hs         = in_valid_i && in_ready_o;

`ifdef V_IQ_BYPASS_EN
   assign byp      = (state == IQ_EMPTY) && !flush_i &&
                     in_valid_i && legal;
   assign byp_take = byp && out_ready_i;
`else
   assign byp      = 1'b0;
   assign byp_take = 1'b0;
`endif

   // A bypassed entry consumed this cycle is never written.
   assign push = hs && legal && !byp_take;
   assign pop  = (state != IQ_EMPTY) && out_ready_i;

   v_iq_fifo #(
      .DEPTH (DEPTH),
      .W     (W)
   ) u_fifo (
      .clk     (clk),
      .wr_en   (push && !flush_i),
      .wr_idx  (wr_q[AW-1:0]),
      .wr_data ({in_rs1_i, in_inst_i}),
      .rd_idx  (rd_q[AW-1:0]),
      .rd_data (rd_data)
   );

   always_comb begin
      out_valid_o = 1'b0;
      out_inst_o  = '0;
      out_rs1_o   = '0;
      if (state != IQ_EMPTY) begin
         out_valid_o = 1'b1;
         out_inst_o  = rd_data[IW-1:0];
         out_rs1_o   = rd_data[W-1:IW];
      end else if (byp) begin
         out_valid_o = 1'b1;
         out_inst_o  = in_inst_i;
         out_rs1_o   = in_rs1_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         err_q <= 1'b0;
      end else begin
         err_q <= hs && !legal;
         if (flush_i) begin
            rd_q <= '0;
            wr_q <= '0;
         end else begin
            if (push) begin
               wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
               rd_q <= rd_q + 1'b1;
            end
         end
      end
   end

   assign count_o = wr_q - rd_q;
   assign idle_o  = empty && !in_valid_i;
   assign err_o   = err_q;

endmodule

// File: tb/tb_v_inst_queue.sv
// Directed self-checking bench for v_inst_queue.
// Bypass expectations follow V_IQ_BYPASS_EN when defined.
module tb_v_inst_queue;

   logic        clk;
   logic        rst;
   logic        flush_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] in_inst_i;
   logic [63:0] in_rs1_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] out_inst_o;
   logic [63:0] out_rs1_o;
   logic [2:0]  count_o;
   logic        idle_o;
   logic        err_o;

   int n_checks;
   int n_errors;

   logic [31:0] v5 [5];

   v_inst_queue u_dut (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_inst_i   (in_inst_i),
      .in_rs1_i    (in_rs1_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_inst_o  (out_inst_o),
      .out_rs1_o   (out_rs1_o),
      .count_o     (count_o),
      .idle_o      (idle_o),
      .err_o       (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(
      input string       tag,
      input logic [63:0] got,
      input logic [63:0] exp
   );
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(
      input logic [31:0] inst,
      input logic [63:0] rs1
   );
      in_valid_i = 1'b1;
      in_inst_i  = inst;
      in_rs1_i   = rs1;
      step();
      in_valid_i = 1'b0;
   endtask

   function automatic logic [31:0] mk(input int k);
      return {k[24:0], 7'h57};
   endfunction

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      rst         = 1'b0;
      flush_i     = 1'b0;
      in_valid_i  = 1'b0;
      in_inst_i   = '0;
      in_rs1_i    = '0;
      out_ready_i = 1'b0;
      v5[0] = 32'h02208057;
      v5[1] = 32'h02006007;
      v5[2] = 32'h02007027;
      v5[3] = 32'h5e003057;
      v5[4] = 32'h02208127;

      // reset state
      #2;
      check("rst_count", 64'(count_o), 64'd0);
      check("rst_oval", 64'(out_valid_o), 64'd0);
      check("rst_iready", 64'(in_ready_o), 64'd0);
      check("rst_inst", 64'(out_inst_o), 64'd0);
      check("rst_err", 64'(err_o), 64'd0);
      #10;
      rst = 1'b1;
      #1;
      check("post_rst_iready", 64'(in_ready_o), 64'd1);
      check("idle_empty", 64'(idle_o), 64'd1);

      // single push, head visible next cycle
      in_valid_i = 1'b1;
      in_inst_i  = 32'h02208057;
      in_rs1_i   = 64'h10;
      #1;
      check("idle_inval", 64'(idle_o), 64'd0);
`ifdef V_IQ_BYPASS_EN
      check("lat_same", 64'(out_valid_o), 64'd1);
`else
      check("lat_same", 64'(out_valid_o), 64'd0);
`endif
      step();
      in_valid_i = 1'b0;
      check("p1_oval", 64'(out_valid_o), 64'd1);
      check("p1_inst", 64'(out_inst_o), 64'h02208057);
      check("p1_rs1", out_rs1_o, 64'h10);
      check("p1_count", 64'(count_o), 64'd1);
      out_ready_i = 1'b1;
      step();
      out_ready_i = 1'b0;
      check("p1_drain", 64'(count_o), 64'd0);

      // fill to full, 5th held by source
      for (int i = 0; i < 4; i++) begin
         in_valid_i = 1'b1;
         in_inst_i  = v5[i];
         in_rs1_i   = 64'(i + 1);
         #1;
         check("fill_ready", 64'(in_ready_o), 64'd1);
         step();
      end
      in_inst_i = v5[4];
      in_rs1_i  = 64'd5;
      check("full_count", 64'(count_o), 64'd4);
      check("full_ready", 64'(in_ready_o), 64'd0);
      step();
      check("held_count", 64'(count_o), 64'd4);
      check("held_head", 64'(out_inst_o), 64'(v5[0]));
      out_ready_i = 1'b1;
      #1;
      check("full_pop_ready", 64'(in_ready_o), 64'd0);
      step();
      check("pop0_count", 64'(count_o), 64'd3);
      check("pop0_head", 64'(out_inst_o), 64'(v5[1]));
      check("pop0_rs1", out_rs1_o, 64'd2);
      check("pop0_ready", 64'(in_ready_o), 64'd1);
      step();
      in_valid_i = 1'b0;
      check("p5_count", 64'(count_o), 64'd3);
      check("p5_head", 64'(out_inst_o), 64'(v5[2]));
      step();
      check("d3_head", 64'(out_inst_o), 64'(v5[3]));
      step();
      check("d4_head", 64'(out_inst_o), 64'(v5[4]));
      check("d4_rs1", out_rs1_o, 64'd5);
      step();
      check("d_count", 64'(count_o), 64'd0);
      check("d_oval", 64'(out_valid_o), 64'd0);
      out_ready_i = 1'b0;

      // steady push + pop with pointer wrap
      push_one(mk(0), 64'h100);
      for (int k = 0; k < 20; k++) begin
         in_valid_i  = 1'b1;
         in_inst_i   = mk(k + 1);
         in_rs1_i    = 64'h100 + 64'(k + 1);
         out_ready_i = 1'b1;
         #1;
         check("ss_head", 64'(out_inst_o), 64'(mk(k)));
         check("ss_rs1", out_rs1_o, 64'h100 + 64'(k));
         step();
         check("ss_count", 64'(count_o), 64'd1);
      end
      in_valid_i = 1'b0;
      #1;
      check("ss_last", 64'(out_inst_o), 64'(mk(20)));
      step();
      out_ready_i = 1'b0;
      check("ss_end", 64'(count_o), 64'd0);

      // illegal opcode
      check("err_idle", 64'(err_o), 64'd0);
      push_one(32'h00000033, 64'h7);
      check("err_pulse", 64'(err_o), 64'd1);
      check("err_count", 64'(count_o), 64'd0);
      step();
      check("err_clear", 64'(err_o), 64'd0);

      // flush with same-cycle push
      for (int i = 0; i < 3; i++) begin
         push_one(v5[i], 64'(i));
      end
      check("pre_flush", 64'(count_o), 64'd3);
      flush_i    = 1'b1;
      in_valid_i = 1'b1;
      in_inst_i  = v5[3];
      #1;
      check("flush_ready", 64'(in_ready_o), 64'd0);
      check("flush_oval", 64'(out_valid_o), 64'd1);
      step();
      flush_i    = 1'b0;
      in_valid_i = 1'b0;
      #1;
      check("flush_count", 64'(count_o), 64'd0);
      check("flush_oval2", 64'(out_valid_o), 64'd0);
      check("flush_idle", 64'(idle_o), 64'd1);

      // async reset mid-stream
      push_one(v5[0], 64'h11);
      push_one(v5[1], 64'h22);
      check("mid_count", 64'(count_o), 64'd2);
      #2;
      rst = 1'b0;
      #1;
      check("arst_count", 64'(count_o), 64'd0);
      check("arst_oval", 64'(out_valid_o), 64'd0);
      check("arst_inst", 64'(out_inst_o), 64'd0);
      check("arst_rs1", out_rs1_o, 64'd0);
      check("arst_ready", 64'(in_ready_o), 64'd0);
      rst = 1'b1;
      step();

`ifdef V_IQ_BYPASS_EN
      in_valid_i  = 1'b1;
      in_inst_i   = v5[2];
      in_rs1_i    = 64'h33;
      out_ready_i = 1'b1;
      #1;
      check("byp_oval", 64'(out_valid_o), 64'd1);
      check("byp_inst", 64'(out_inst_o), 64'(v5[2]));
      check("byp_rs1", out_rs1_o, 64'h33);
      step();
      in_valid_i  = 1'b0;
      out_ready_i = 1'b0;
      check("byp_count", 64'(count_o), 64'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
